// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 size codes, LSU FSM states
// and small decode helpers used by the LSU datapath and controller.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RSP,
        LSU_DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_B,
        SIZE_H,
        SIZE_W
    } lsu_size_e;

    // Unused funct3 codes (011, 110, 111) fall through to a word access.
    function automatic lsu_size_e decode_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SIZE_B;
            F3_H, F3_HU: return SIZE_H;
            default:     return SIZE_W;
        endcase
    endfunction

    function automatic logic is_unsigned(input logic [2:0] funct3);
        return (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bundles the core-side request/response and the memory-side handshake of
// the load/store unit. slave = the LSU itself, master = core plus memory.
interface lsu_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic [31:0]       rdata;
    logic              done;
    logic              misaligned;
    logic              bus_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output stall, rdata, done, misaligned, bus_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  stall, rdata, done, misaligned, bus_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering for RV32I loads/stores: byte enables,
// store-data replication, load extract with sign/zero extension and
// alignment check.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] ext_rdata,
    output logic        misaligned
);
    lsu_size_e   size;
    logic        uns;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Decode the access size and steer lanes in both directions.
    always_comb begin
        size       = decode_size(funct3);
        uns        = is_unsigned(funct3);
        sel_byte   = raw_rdata[{addr_lo, 3'b000} +: 8];
        sel_half   = addr_lo[1] ? raw_rdata[31:16] : raw_rdata[15:0];
        be         = 4'b1111;
        lane_wdata = wdata;
        ext_rdata  = raw_rdata;
        misaligned = 1'b0;
        case (size)
            SIZE_B: begin
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
                ext_rdata  = uns ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            end
            SIZE_H: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                ext_rdata  = uns ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit controller: turns a core access into one handshaked,
// word-aligned memory transaction, stalls the core until completion and
// flags misaligned accesses and response timeouts.
module lsu_mem_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic          clk,
    input  logic          reset,
    lsu_mem_ctrl_if.slave bus
);
    lsu_state_e  state;
    logic [7:0]  cnt;
    logic [31:0] rdata_q;
    logic        mem_req_q;
    logic        done_q;
    logic        mis_q;
    logic        berr_q;

    logic [3:0]  be;
    logic [31:0] lane_wdata;
    logic [31:0] ext_rdata;
    logic        misaligned;

    lsu_align u_align (
        .funct3     (bus.req_funct3),
        .addr_lo    (bus.req_addr[1:0]),
        .wdata      (bus.req_wdata),
        .raw_rdata  (bus.mem_rdata),
        .be         (be),
        .lane_wdata (lane_wdata),
        .ext_rdata  (ext_rdata),
        .misaligned (misaligned)
    );

    // Access sequencing, timeout counting and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LSU_IDLE;
            cnt       <= '0;
            rdata_q   <= '0;
            mem_req_q <= 1'b0;
            done_q    <= 1'b0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            berr_q <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (bus.req_valid) begin
                        if (misaligned) begin
                            state  <= LSU_DONE;
                            done_q <= 1'b1;
                            mis_q  <= 1'b1;
                        end else begin
                            state     <= LSU_REQ;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                LSU_REQ: begin
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (bus.req_we) begin
                            state  <= LSU_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= LSU_WAIT_RSP;
                            cnt   <= '0;
                        end
                    end
                end
                LSU_WAIT_RSP: begin
                    cnt <= cnt + 8'd1;
                    if (bus.mem_rvalid) begin
                        rdata_q <= ext_rdata;
                        state   <= LSU_DONE;
                        done_q  <= 1'b1;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        rdata_q <= '0;
                        state   <= LSU_DONE;
                        done_q  <= 1'b1;
                        berr_q  <= 1'b1;
                    end
                end
                LSU_DONE: begin
                    state <= LSU_IDLE;
                end
                default: begin
                    state <= LSU_IDLE;
                end
            endcase
        end
    end

    // Core stall is combinational so the first request cycle already freezes the core.
    always_comb begin
        bus.stall      = bus.req_valid & (state != LSU_DONE) & ~reset;
        bus.rdata      = rdata_q;
        bus.done       = done_q;
        bus.misaligned = mis_q;
        bus.bus_err    = berr_q;
        bus.mem_req    = mem_req_q;
        bus.mem_we     = mem_req_q & bus.req_we;
        bus.mem_addr   = {bus.req_addr[ADDR_W-1:2], 2'b00};
        bus.mem_be     = be;
        bus.mem_wdata  = lane_wdata;
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized
// accesses compared against an arithmetic reference model.
module tb_lsu_mem_ctrl;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();

    lsu_mem_ctrl #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_hold = '0;

    // Observations collected by run_access.
    int          o_done_cyc, o_stall_cnt, o_req_cnt, o_done_cnt, o_extra_busy;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata, o_rdata, o_rdata_post;
    logic        o_we, o_mis, o_berr, o_timeout;

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [31:0] addr);
        int s = m_size(f3);
        return (int'(addr % 32'd4) / s) * s;
    endfunction

    function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr % 32'd4) % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int s = m_size(f3);
        return 4'(((1 << s) - 1) << m_off(f3, addr));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int s = m_size(f3);
        if (s == 1) return 32'(wd % 256) * 32'h01010101;
        if (s == 2) return 32'(wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
        int s = m_size(f3);
        longint v = (longint'(word) >> (8 * m_off(f3, addr))) & ((64'sd1 <<< (8 * s)) - 1);
        if (f3 < 3'd4 && s < 4 && v >= (64'sd1 <<< (8 * s - 1))) v = v - (64'sd1 <<< (8 * s));
        return 32'(v);
    endfunction

    // ---------------- driver ----------------
    // Must be called right after a negedge; returns right after a negedge.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int gnt_delay, input int rsp_delay,
                              input logic [31:0] word, input int post_idle);
        bit finished = 0;
        bit granted = 0;
        int gnt_cyc = 0;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        o_done_cyc = 0; o_stall_cnt = 0; o_req_cnt = 0; o_done_cnt = 0; o_extra_busy = 0;
        o_be = '0; o_addr = '0; o_wdata = '0; o_we = 1'b0; o_mis = 1'b0; o_berr = 1'b0;
        o_rdata = '0; o_timeout = 1'b0;
        for (int k = 1; k <= 100 && !finished; k++) begin
            #1;
            if (bus.stall) o_stall_cnt++;
            if (bus.done) begin
                o_done_cnt++; o_done_cyc = k; o_mis = bus.misaligned; o_berr = bus.bus_err;
                o_rdata = bus.rdata; finished = 1;
                bus.req_valid = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
            end else begin
                bus.mem_gnt = 1'b0;
                if (bus.mem_req) begin
                    o_req_cnt++; o_be = bus.mem_be; o_addr = bus.mem_addr;
                    o_wdata = bus.mem_wdata; o_we = bus.mem_we;
                    if (o_req_cnt > gnt_delay) begin
                        bus.mem_gnt = 1'b1; granted = 1; gnt_cyc = k;
                    end
                end
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata = $urandom;
                if (granted && rsp_delay > 0 && k - gnt_cyc == rsp_delay) begin
                    bus.mem_rvalid = 1'b1; bus.mem_rdata = word;
                end
            end
            @(negedge clk);
        end
        if (!finished) o_timeout = 1'b1;
        o_rdata_post = o_rdata;
        for (int i = 0; i < post_idle; i++) begin
            #1;
            if (bus.done) o_done_cnt++;
            if (bus.mem_req || bus.stall) o_extra_busy++;
            o_rdata_post = bus.rdata;
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h40; bus.req_wdata = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests_run++; if (bus.stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
        tests_run++; if (bus.mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
        tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        tests_run++; if (bus.misaligned !== 1'b0) begin tests_failed++; $display("FAIL reset_mis got=%b exp=0", bus.misaligned); end
        tests_run++; if (bus.bus_err !== 1'b0) begin tests_failed++; $display("FAIL reset_berr got=%b exp=0", bus.bus_err); end
        tests_run++; if (bus.rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_hold = '0;
    endtask

    task automatic test_store_word();
        run_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, '0, 2);
        tests_run++; if (o_addr !== 32'h100) begin tests_failed++; $display("FAIL sw_addr got=%h exp=00000100", o_addr); end
        tests_run++; if (o_be !== 4'b1111) begin tests_failed++; $display("FAIL sw_be got=%b exp=1111", o_be); end
        tests_run++; if (o_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL sw_wdata got=%h exp=deadbeef", o_wdata); end
        tests_run++; if (o_we !== 1'b1) begin tests_failed++; $display("FAIL sw_we got=%b exp=1", o_we); end
        tests_run++; if (o_done_cyc != 3) begin tests_failed++; $display("FAIL sw_done_cycle got=%0d exp=3", o_done_cyc); end
        tests_run++; if (o_stall_cnt != 2) begin tests_failed++; $display("FAIL sw_stall_cycles got=%0d exp=2", o_stall_cnt); end
        tests_run++; if (o_done_cnt != 1) begin tests_failed++; $display("FAIL sw_done_pulses got=%0d exp=1", o_done_cnt); end
        tests_run++; if (o_mis !== 1'b0 || o_berr !== 1'b0) begin tests_failed++; $display("FAIL sw_flags got=%b%b exp=00", o_mis, o_berr); end
    endtask

    task automatic test_load_byte();
        run_access(1'b0, 3'b000, 32'h203, '0, 0, 2, 32'h80FF7F01, 2);
        exp_hold = 32'hFFFFFF80;
        tests_run++; if (o_rdata !== exp_hold) begin tests_failed++; $display("FAIL lb_rdata got=%h exp=%h", o_rdata, exp_hold); end
        tests_run++; if (o_done_cyc != 5) begin tests_failed++; $display("FAIL lb_done_cycle got=%0d exp=5", o_done_cyc); end
        tests_run++; if (o_addr !== 32'h200 || o_be !== 4'b1000 || o_we !== 1'b0) begin tests_failed++; $display("FAIL lb_bus got=%h/%b/%b exp=00000200/1000/0", o_addr, o_be, o_we); end
        tests_run++; if (o_rdata_post !== exp_hold) begin tests_failed++; $display("FAIL lb_rdata_hold got=%h exp=%h", o_rdata_post, exp_hold); end
        run_access(1'b0, 3'b100, 32'h203, '0, 0, 2, 32'h80FF7F01, 0);
        exp_hold = 32'h00000080;
        tests_run++; if (o_rdata !== exp_hold) begin tests_failed++; $display("FAIL lbu_rdata got=%h exp=%h", o_rdata, exp_hold); end
    endtask

    task automatic test_store_half_delayed();
        run_access(1'b1, 3'b001, 32'h06, 32'h1234ABCD, 3, 0, '0, 2);
        tests_run++; if (o_req_cnt != 4) begin tests_failed++; $display("FAIL sh_req_cycles got=%0d exp=4", o_req_cnt); end
        tests_run++; if (o_be !== 4'b1100) begin tests_failed++; $display("FAIL sh_be got=%b exp=1100", o_be); end
        tests_run++; if (o_wdata !== 32'hABCDABCD) begin tests_failed++; $display("FAIL sh_wdata got=%h exp=abcdabcd", o_wdata); end
        tests_run++; if (o_addr !== 32'h04) begin tests_failed++; $display("FAIL sh_addr got=%h exp=00000004", o_addr); end
        tests_run++; if (o_done_cnt != 1 || o_done_cyc != 6) begin tests_failed++; $display("FAIL sh_done got=%0d@%0d exp=1@6", o_done_cnt, o_done_cyc); end
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 3'b010, 32'h102, '0, 0, 1, 32'h11111111, 2);
        tests_run++; if (o_mis !== 1'b1 || o_berr !== 1'b0) begin tests_failed++; $display("FAIL lw_mis_flags got=%b%b exp=10", o_mis, o_berr); end
        tests_run++; if (o_done_cyc != 2) begin tests_failed++; $display("FAIL lw_mis_done_cycle got=%0d exp=2", o_done_cyc); end
        tests_run++; if (o_req_cnt != 0) begin tests_failed++; $display("FAIL lw_mis_mem_req got=%0d exp=0", o_req_cnt); end
        tests_run++; if (o_rdata_post !== exp_hold) begin tests_failed++; $display("FAIL lw_mis_rdata got=%h exp=%h", o_rdata_post, exp_hold); end
        run_access(1'b1, 3'b001, 32'h201, 32'h5555, 0, 0, '0, 1);
        tests_run++; if (o_mis !== 1'b1 || o_req_cnt != 0) begin tests_failed++; $display("FAIL sh_mis got=%b/%0d exp=1/0", o_mis, o_req_cnt); end
    endtask

    task automatic test_timeout();
        logic [31:0] w;
        run_access(1'b0, 3'b001, 32'h10, '0, 0, 0, '0, 1);
        exp_hold = '0;
        tests_run++; if (o_berr !== 1'b1 || o_mis !== 1'b0) begin tests_failed++; $display("FAIL lh_to_flags got=%b%b exp=01", o_mis, o_berr); end
        tests_run++; if (o_rdata !== 32'h0) begin tests_failed++; $display("FAIL lh_to_rdata got=%h exp=0", o_rdata); end
        tests_run++; if (o_done_cyc != 3 + TO) begin tests_failed++; $display("FAIL lh_to_done_cycle got=%0d exp=%0d", o_done_cyc, 3 + TO); end
        w = 32'h0000F00D;
        run_access(1'b0, 3'b001, 32'h10, '0, 0, TO, w, 1);
        exp_hold = 32'hFFFFF00D;
        tests_run++; if (o_berr !== 1'b0 || o_rdata !== exp_hold) begin tests_failed++; $display("FAIL lh_last_rsp got=%b/%h exp=0/%h", o_berr, o_rdata, exp_hold); end
        tests_run++; if (o_done_cyc != 3 + TO) begin tests_failed++; $display("FAIL lh_last_rsp_cycle got=%0d exp=%0d", o_done_cyc, 3 + TO); end
        run_access(1'b0, 3'b010, 32'h20, '0, 1, TO + 1, 32'h12345678, 1);
        exp_hold = '0;
        tests_run++; if (o_berr !== 1'b1 || o_rdata !== 32'h0) begin tests_failed++; $display("FAIL lw_late_rsp got=%b/%h exp=1/0", o_berr, o_rdata); end
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h80; bus.req_wdata = '0;
        @(negedge clk);
        #1 bus.mem_gnt = bus.mem_req;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        @(negedge clk);
        #3 reset = 1'b1; bus.req_valid = 1'b0;
        #1;
        tests_run++; if (bus.mem_req !== 1'b0 || bus.done !== 1'b0 || bus.rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_async got=%b/%b/%h exp=0/0/0", bus.mem_req, bus.done, bus.rdata); end
        @(negedge clk);
        reset = 1'b0;
        exp_hold = '0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
            #1;
            tests_run++; if (bus.done !== 1'b0 || bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_idle[%0d] got=%b/%b/%b/%h exp=0/0/0/0", i, bus.done, bus.mem_req, bus.stall, bus.rdata); end
            @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
        run_access(1'b1, 3'b010, 32'h84, 32'h1, 0, 0, '0, 1);
        tests_run++; if (o_done_cyc != 3) begin tests_failed++; $display("FAIL rst_mid_restart got=%0d exp=3", o_done_cyc); end
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 3'b000, 32'h31, 32'hA5, 0, 0, '0, 0);
        tests_run++; if (o_done_cyc != 3 || o_wdata !== 32'hA5A5A5A5 || o_be !== 4'b0010) begin tests_failed++; $display("FAIL b2b_sb got=%0d/%h/%b exp=3/a5a5a5a5/0010", o_done_cyc, o_wdata, o_be); end
        run_access(1'b0, 3'b101, 32'h32, '0, 0, 1, 32'h8001_0000, 2);
        exp_hold = 32'h00008001;
        tests_run++; if (o_done_cyc != 4 || o_rdata !== exp_hold) begin tests_failed++; $display("FAIL b2b_lhu got=%0d/%h exp=4/%h", o_done_cyc, o_rdata, exp_hold); end
        tests_run++; if (o_done_cnt != 1 || o_extra_busy != 0) begin tests_failed++; $display("FAIL b2b_tail got=%0d/%0d exp=1/0", o_done_cnt, o_extra_busy); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic        we = 1'($urandom_range(0, 1));
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic [31:0] addr = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] word = $urandom;
            int gd = $urandom_range(0, 3);
            int rd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(1, 4);
            int pi = $urandom_range(0, 1);
            bit mis = m_mis(f3, addr);
            bit ok = (rd >= 1 && rd <= TO);
            bit exp_berr = !mis && !we && !ok;
            int exp_cyc = mis ? 2 : (we ? 3 + gd : 3 + gd + (ok ? rd : TO));
            run_access(we, f3, addr, wd, gd, rd, word, pi);
            if (!mis && !we) exp_hold = ok ? m_load(f3, addr, word) : 32'h0;
            tests_run++; if (o_timeout || o_done_cyc != exp_cyc || o_done_cnt != 1) begin tests_failed++; $display("FAIL rnd%0d_done got=%0d x%0d exp=%0d x1", n, o_done_cyc, o_done_cnt, exp_cyc); end
            tests_run++; if (o_mis !== mis || o_berr !== exp_berr) begin tests_failed++; $display("FAIL rnd%0d_flags got=%b%b exp=%b%b", n, o_mis, o_berr, mis, exp_berr); end
            tests_run++; if (o_rdata !== exp_hold || o_rdata_post !== exp_hold) begin tests_failed++; $display("FAIL rnd%0d_rdata got=%h/%h exp=%h", n, o_rdata, o_rdata_post, exp_hold); end
            tests_run++; if (o_req_cnt != (mis ? 0 : gd + 1) || o_stall_cnt != exp_cyc - 1) begin tests_failed++; $display("FAIL rnd%0d_req_stall got=%0d/%0d exp=%0d/%0d", n, o_req_cnt, o_stall_cnt, mis ? 0 : gd + 1, exp_cyc - 1); end
            if (!mis) begin
                tests_run++; if (o_be !== m_be(f3, addr) || o_addr !== {addr[31:2], 2'b00} || o_we !== we) begin tests_failed++; $display("FAIL rnd%0d_bus got=%b/%h/%b exp=%b/%h/%b", n, o_be, o_addr, o_we, m_be(f3, addr), {addr[31:2], 2'b00}, we); end
                if (we) begin
                    tests_run++; if (o_wdata !== m_wdata(f3, wd)) begin tests_failed++; $display("FAIL rnd%0d_wdata got=%h exp=%h", n, o_wdata, m_wdata(f3, wd)); end
                end
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        test_reset();
        test_store_word();
        test_load_byte();
        test_store_half_delayed();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
